approx_mult_seq_ctrl: RTL and testbench



---
 rtl/approx_mult_seq_ctrl_pkg.sv | 38 +++
 rtl/approx_mult_seq_ctrl_if.sv | 37 +++
 rtl/approx_mult_seq_ctrl_norm_counter.sv | 37 +++
 rtl/approx_mult_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_approx_mult_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_seq_ctrl_pkg.sv
// Shared types, width helpers and the shift-back amount formula for the
// leading-one-truncation multiplier sequencer.
package approx_mult_pkg;

  typedef enum logic [2:0] {
    IDLE, ARM, RD1, RD2, NORM, SHIFT, WR, DONE
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_SEG_W   = 8;
  localparam int DEF_N_PAIRS = 8;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

  function automatic int amt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  function automatic int idx_w(input int n_pairs);
    return (n_pairs > 1) ? $clog2(n_pairs) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DEF_DATA_W);
  localparam int AMT_W = amt_w(DEF_DATA_W);
  localparam int IDX_W = idx_w(DEF_N_PAIRS);

  // Left shifts needed to undo normalisation; saturates at 0 when the
  // operands were shifted further than the segment truncation accounts for.
  function automatic int shift_back_amt(input int data_w, input int seg_w,
                                        input int c1, input int c2);
    int t;
    t = 2 * (data_w - seg_w) - c1 - c2;
    return (t < 0) ? 0 : t;
  endfunction

endpackage

// File: rtl/approx_mult_seq_ctrl_if.sv
// Control/status bundle between the sequencer and the multiplier datapath.
interface approx_mult_seq_ctrl_if
  import approx_mult_pkg::*;
#(
  parameter int ADDR_W = 8
);
  // start is a level request: the run begins only once it is released again;
  // start while busy is ignored, abort drops any active run back to IDLE.
  logic              start;
  logic              abort;
  logic              msb1;
  logic              msb2;
  logic [ADDR_W-1:0] ram_addr;
  logic              ld_op1;
  logic              ld_op2;
  logic              sh_op1;
  logic              sh_op2;
  logic              mul_en;
  logic              clr_res;
  logic              sh_res;
  logic              wr_ram;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  modport master (
    input  start, abort, msb1, msb2,
    output ram_addr, ld_op1, ld_op2, sh_op1, sh_op2, mul_en, clr_res,
           sh_res, wr_ram, busy, done, dbg_state
  );

  modport slave (
    output start, abort, msb1, msb2,
    input  ram_addr, ld_op1, ld_op2, sh_op1, sh_op2, mul_en, clr_res,
           sh_res, wr_ram, busy, done, dbg_state
  );
endinterface

// File: rtl/approx_mult_seq_ctrl_norm_counter.sv
// Per-operand normalisation counter: shifts until the MSB is set or the
// operand has been shifted DATA_W-1 times (an all-zero operand).
module norm_counter
  import approx_mult_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int CW     = cnt_w(DATA_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_msb,
  output logic [CW-1:0] o_cnt,
  output logic          o_shift,
  output logic          o_finished,
  output logic          o_zero
);
  localparam logic [CW-1:0] C_MAX = CW'(DATA_W - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max   = (r_cnt == C_MAX);
  assign o_shift    = i_en && !i_msb && !w_at_max;
  assign o_finished = i_msb || w_at_max;
  assign o_zero     = o_finished && !i_msb;
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequencer walking N_PAIRS operand pairs: read, normalise, segment multiply,
// shift back and write each approximate product.
module approx_mult_seq_ctrl
  import approx_mult_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                SEG_W    = DEF_SEG_W,
  parameter int                N_PAIRS  = DEF_N_PAIRS,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RES_BASE = 'h80
) (
  input logic                    clk,
  input logic                    rst,
  approx_mult_seq_ctrl_if.master bus
);
  localparam int CW = cnt_w(DATA_W);
  localparam int AW = amt_w(DATA_W);
  localparam int IW = idx_w(N_PAIRS);

  state_t        r_state, w_nxt;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_amt, w_amt_calc;
  logic [CW-1:0] w_cnt1, w_cnt2;
  logic          w_sh1, w_sh2, w_fin1, w_fin2, w_zero1, w_zero2;
  logic          w_clr1, w_clr2, w_norm_en, w_amt_ld, w_idx_inc;

  norm_counter #(.DATA_W(DATA_W)) u_norm1 (
    .clk(clk), .rst(rst), .i_clr(w_clr1), .i_en(w_norm_en), .i_msb(bus.msb1),
    .o_cnt(w_cnt1), .o_shift(w_sh1), .o_finished(w_fin1), .o_zero(w_zero1)
  );

  norm_counter #(.DATA_W(DATA_W)) u_norm2 (
    .clk(clk), .rst(rst), .i_clr(w_clr2), .i_en(w_norm_en), .i_msb(bus.msb2),
    .o_cnt(w_cnt2), .o_shift(w_sh2), .o_finished(w_fin2), .o_zero(w_zero2)
  );

  assign w_amt_calc    = AW'(shift_back_amt(DATA_W, SEG_W, int'(w_cnt1), int'(w_cnt2)));
  assign bus.sh_op1    = w_sh1;
  assign bus.sh_op2    = w_sh2;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

  always_comb begin
    w_nxt       = r_state;
    w_clr1      = 1'b0;
    w_clr2      = 1'b0;
    w_norm_en   = 1'b0;
    w_amt_ld    = 1'b0;
    w_idx_inc   = 1'b0;
    bus.ram_addr = '0;
    bus.ld_op1  = 1'b0;
    bus.ld_op2  = 1'b0;
    bus.mul_en  = 1'b0;
    bus.clr_res = 1'b0;
    bus.sh_res  = 1'b0;
    bus.wr_ram  = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_nxt = ARM;
      ARM:  if (!bus.start) w_nxt = RD1;
      RD1: begin
        bus.ram_addr = ADDR_W'({r_idx, 1'b0});
        bus.ld_op1   = 1'b1;
        w_clr1       = 1'b1;
        w_nxt        = RD2;
      end
      RD2: begin
        bus.ram_addr = ADDR_W'({r_idx, 1'b1});
        bus.ld_op2   = 1'b1;
        w_clr2       = 1'b1;
        w_nxt        = NORM;
      end
      NORM: begin
        w_norm_en = 1'b1;
        // Exit only once both operands are finished; no shift is issued then.
        if (w_fin1 && w_fin2) begin
          if (w_zero1 || w_zero2) begin
            bus.clr_res = 1'b1;
            w_nxt       = WR;
          end else begin
            bus.mul_en = 1'b1;
            w_amt_ld   = 1'b1;
            w_nxt      = (w_amt_calc == '0) ? WR : SHIFT;
          end
        end
      end
      SHIFT: begin
        bus.sh_res = 1'b1;
        if (r_amt <= AW'(1)) w_nxt = WR;
      end
      WR: begin
        bus.ram_addr = RES_BASE + ADDR_W'(r_idx);
        bus.wr_ram   = 1'b1;
        if (r_idx == IW'(N_PAIRS - 1)) begin
          w_nxt = DONE;
        end else begin
          w_idx_inc = 1'b1;
          w_nxt     = RD1;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        w_nxt    = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (bus.abort && r_state != IDLE) w_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_amt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE) r_idx <= '0;
      else if (w_idx_inc)  r_idx <= r_idx + 1'b1;
      if (w_amt_ld) r_amt <= w_amt_calc;
      else if (r_state == SHIFT && r_amt != '0) r_amt <= r_amt - 1'b1;
    end
  end
endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Directed bench: a small RAM and operand shift registers around the
// sequencer, with per-pair pulse statistics gathered by a monitor.
module tb_approx_mult_seq_ctrl;
  import approx_mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  approx_mult_seq_ctrl_if #(.ADDR_W(8)) bus ();

  approx_mult_seq_ctrl #(
    .DATA_W(16), .SEG_W(8), .N_PAIRS(8), .ADDR_W(8), .RES_BASE(8'h80)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Datapath model: asynchronous-read RAM feeding two operand shift registers.
  logic [15:0] ram [256];
  logic [15:0] op1, op2;
  logic [15:0] rd_data;

  assign rd_data  = ram[bus.ram_addr];
  assign bus.msb1 = op1[15];
  assign bus.msb2 = op2[15];

  always @(posedge clk) begin
    if (bus.ld_op1)      op1 <= rd_data;
    else if (bus.sh_op1) op1 <= {op1[14:0], 1'b0};
    if (bus.ld_op2)      op2 <= rd_data;
    else if (bus.sh_op2) op2 <= {op2[14:0], 1'b0};
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  int cur_norm, cur_sh1, cur_sh2, cur_mul, cur_clr, cur_shres;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int rec_norm[64], rec_sh1[64], rec_sh2[64], rec_mul[64], rec_clr[64];
  int rec_shres[64], rec_cyc[64];
  logic [7:0] rec_addr[64];
  logic [7:0] rd_log[64];

  always @(negedge clk) begin
    if (bus.ld_op1) begin
      cur_norm = 0; cur_sh1 = 0; cur_sh2 = 0;
      cur_mul = 0; cur_clr = 0; cur_shres = 0;
    end
    if (bus.ld_op1 || bus.ld_op2) begin
      if (rd_cnt < 64) rd_log[rd_cnt] = bus.ram_addr;
      rd_cnt++;
    end
    if (bus.dbg_state == NORM) cur_norm++;
    if (bus.sh_op1)  cur_sh1++;
    if (bus.sh_op2)  cur_sh2++;
    if (bus.mul_en)  cur_mul++;
    if (bus.clr_res) cur_clr++;
    if (bus.sh_res)  cur_shres++;
    if (bus.wr_ram && wr_cnt < 64) begin
      rec_norm[wr_cnt] = cur_norm;  rec_sh1[wr_cnt] = cur_sh1;
      rec_sh2[wr_cnt]  = cur_sh2;   rec_mul[wr_cnt] = cur_mul;
      rec_clr[wr_cnt]  = cur_clr;   rec_shres[wr_cnt] = cur_shres;
      rec_addr[wr_cnt] = bus.ram_addr; rec_cyc[wr_cnt] = cyc;
      wr_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  // Hand-computed per-pair expectations (DATA_W=16, SEG_W=8).
  logic [15:0] pair_a[8]  = '{16'h0300, 16'h8000, 16'h0000, 16'h0080,
                              16'h00FF, 16'hFFFF, 16'h4000, 16'h1000};
  logic [15:0] pair_b[8]  = '{16'h0041, 16'hFFFF, 16'h1234, 16'h0080,
                              16'h0001, 16'h0000, 16'h2000, 16'h0100};
  int exp_norm[8]  = '{10, 1, 16, 9, 16, 16, 3, 8};
  int exp_sh1[8]   = '{ 6, 0, 15, 8,  8,  0, 1, 3};
  int exp_sh2[8]   = '{ 9, 0,  3, 8, 15, 15, 2, 7};
  int exp_mul[8]   = '{ 1, 1,  0, 1,  1,  0, 1, 1};
  int exp_clr[8]   = '{ 0, 0,  1, 0,  0,  1, 0, 0};
  int exp_shres[8] = '{ 1, 16, 0, 0,  0,  0, 13, 6};

  logic [7:0] exp_q[$];

  function automatic logic [17:0] out_vec();
    return {bus.ram_addr, bus.ld_op1, bus.ld_op2, bus.sh_op1, bus.sh_op2,
            bus.mul_en, bus.clr_res, bus.sh_res, bus.wr_ram, bus.busy, bus.done};
  endfunction

  task automatic load_ram();
    for (int p = 0; p < 8; p++) begin
      ram[2*p]   = pair_a[p];
      ram[2*p+1] = pair_b[p];
    end
  endtask

  task automatic wait_state(input state_t s, input int budget, input string nm);
    int n = 0;
    while (bus.dbg_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.dbg_state != s) begin
      failures++;
      $display("FAIL %s: state=%0d required=%0d within %0d cycles", nm, bus.dbg_state, s, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== 18'd0 || bus.dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_outputs: vec=%h state=%0d required 0/IDLE", out_vec(), bus.dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() !== 18'd0) begin
      failures++;
      $display("FAIL idle_after_reset: vec=%h required 0", out_vec());
    end
  endtask

  task automatic test_full_run();
    int wr_base = wr_cnt, rd_base = rd_cnt, done_base = done_cnt, n = 0;
    load_ram();
    for (int p = 0; p < 8; p++) exp_q.push_back(8'h80 + 8'(p));
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.dbg_state !== ARM || bus.busy !== 1'b1 || bus.ld_op1 !== 1'b0) begin
        failures++;
        $display("FAIL arm_hold[%0d]: state=%0d busy=%b required ARM busy=1", k, bus.dbg_state, bus.busy);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    while (!bus.done && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 40) bus.start = 1'b1;
      if (n == 42) bus.start = 1'b0;
    end
    checks++;
    if (!bus.done) begin
      failures++;
      $display("FAIL run_timeout: done=%b required 1", bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== IDLE) begin
      failures++;
      $display("FAIL busy_after_done: busy=%b required 0", bus.busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - done_base !== 1 || wr_cnt - wr_base !== 8) begin
      failures++;
      $display("FAIL run_counts: done=%0d writes=%0d required 1/8", done_cnt - done_base, wr_cnt - wr_base);
    end
    checks++;
    if (done_cyc !== rec_cyc[wr_base + 7] + 1) begin
      failures++;
      $display("FAIL done_after_last_wr: done_cyc=%0d required %0d", done_cyc, rec_cyc[wr_base + 7] + 1);
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (rd_log[rd_base + j] !== 8'(j)) begin
        failures++;
        $display("FAIL rd_addr[%0d]: got=%h required=%h", j, rd_log[rd_base + j], 8'(j));
      end
    end
    for (int p = 0; p < 8; p++) begin
      logic [7:0] ea;
      int r = wr_base + p;
      ea = exp_q.pop_front();
      checks++;
      if (rec_addr[r] !== ea) begin
        failures++;
        $display("FAIL wr_addr[%0d]: got=%h required=%h", p, rec_addr[r], ea);
      end
      checks++;
      if (rec_norm[r] !== exp_norm[p] || rec_sh1[r] !== exp_sh1[p] || rec_sh2[r] !== exp_sh2[p]) begin
        failures++;
        $display("FAIL norm[%0d]: cycles=%0d sh1=%0d sh2=%0d required %0d/%0d/%0d", p,
                 rec_norm[r], rec_sh1[r], rec_sh2[r], exp_norm[p], exp_sh1[p], exp_sh2[p]);
      end
      checks++;
      if (rec_mul[r] !== exp_mul[p] || rec_clr[r] !== exp_clr[p] || rec_shres[r] !== exp_shres[p]) begin
        failures++;
        $display("FAIL product[%0d]: mul=%0d clr=%0d sh_res=%0d required %0d/%0d/%0d", p,
                 rec_mul[r], rec_clr[r], rec_shres[r], exp_mul[p], exp_clr[p], exp_shres[p]);
      end
    end
  endtask

  task automatic test_abort();
    int wr_base = wr_cnt, done_base = done_cnt, n = 0;
    load_ram();
    ram[6] = 16'h8000;
    ram[7] = 16'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!(wr_cnt - wr_base == 3 && bus.dbg_state == SHIFT) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.dbg_state !== SHIFT) begin
      failures++;
      $display("FAIL abort_reach_shift: state=%0d required SHIFT", bus.dbg_state);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.dbg_state !== IDLE || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: state=%0d busy=%b required IDLE/0", bus.dbg_state, bus.busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (wr_cnt - wr_base !== 3 || done_cnt !== done_base) begin
      failures++;
      $display("FAIL abort_no_write: writes=%0d dones=%0d required 3/0", wr_cnt - wr_base, done_cnt - done_base);
    end
  endtask

  task automatic test_reset_mid_run();
    load_ram();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_state(NORM, 50, "reach_norm");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== 18'd0 || bus.dbg_state !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_run: vec=%h state=%0d required 0/IDLE", out_vec(), bus.dbg_state);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_mid_rst: busy=%b required 0", bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    op1 = '0;
    op2 = '0;
    for (int a = 0; a < 256; a++) ram[a] = '0;
    test_reset();
    test_full_run();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
